// File: rtl/vector_write_back_arbiter_if.sv
// Packet type shared by the write-back arbiter and its functional-unit / register-read ports.
// The interface bundles the per-source result handshakes and the single write-back output.
package vector_write_back_arbiter_pkg;
   localparam int TAG_LENGTH  = 6;
   localparam int DATA_LENGTH = 64;

   typedef struct packed {
      logic [TAG_LENGTH-1:0]  tag;
      logic [DATA_LENGTH-1:0] data;
   } data_packet_t;
endpackage

interface vector_write_back_arbiter_if #(
   parameter int NUM_SOURCES = 3
);
   import vector_write_back_arbiter_pkg::*;

   logic [NUM_SOURCES-1:0] fu_valid;
   data_packet_t           fu_packet [NUM_SOURCES];
   logic [NUM_SOURCES-1:0] fu_ready;
   logic                   write_back_request;
   data_packet_t           write_back_packet;
   logic                   idle;

   modport master (
      output fu_valid, fu_packet,
      input  fu_ready, write_back_request, write_back_packet, idle
   );

   modport slave (
      input  fu_valid, fu_packet,
      output fu_ready, write_back_request, write_back_packet, idle
   );
endinterface

// File: rtl/vector_write_back_arbiter.sv
// Per-source result FIFOs drained one packet per cycle toward register read, round-robin.
// A packet always spends at least one cycle in its FIFO; there is no bypass to the output.
module vector_write_back_arbiter
   import vector_write_back_arbiter_pkg::*;
#(
   parameter int NUM_SOURCES = 3,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                      clock,
   input  logic                      reset_n,
   vector_write_back_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SRC_W = $clog2(NUM_SOURCES);
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

   data_packet_t           mem_r    [NUM_SOURCES][FIFO_DEPTH];
   logic [PTR_W-1:0]       rd_ptr_r [NUM_SOURCES];
   logic [PTR_W-1:0]       wr_ptr_r [NUM_SOURCES];
   logic [CNT_W-1:0]       count_r  [NUM_SOURCES];
   logic [SRC_W-1:0]       rr_ptr_r;
   logic                   wb_request_r;
   data_packet_t           wb_packet_r;

   logic [NUM_SOURCES-1:0] ready_s;
   logic [NUM_SOURCES-1:0] push_s;
   logic [NUM_SOURCES-1:0] pop_s;
   logic [NUM_SOURCES-1:0] nonempty_s;
   logic [SRC_W-1:0]       grant_s;
   logic                   grant_valid_s;
   logic                   idle_s;

   function automatic logic [SRC_W-1:0] wrap_index(input logic [SRC_W-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      sum = (sum >= NUM_SOURCES) ? (sum - NUM_SOURCES) : sum;
      return SRC_W'(sum);
   endfunction

   // Per-source status; a full FIFO stays not-ready even when it is popped this cycle
   always_comb begin
      ready_s    = '0;
      nonempty_s = '0;
      push_s     = '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         ready_s[i]    = (count_r[i] != FULL_COUNT);
         nonempty_s[i] = (count_r[i] != '0);
         push_s[i]     = bus.fu_valid[i] & ready_s[i];
      end
   end

   // Round-robin grant: scanning offsets downward lets the nearest non-empty source win
   always_comb begin
      grant_s       = '0;
      grant_valid_s = 1'b0;
      for (int off = NUM_SOURCES - 1; off >= 0; off--) begin
         grant_s       = nonempty_s[wrap_index(rr_ptr_r, off)] ? wrap_index(rr_ptr_r, off) : grant_s;
         grant_valid_s = grant_valid_s | nonempty_s[wrap_index(rr_ptr_r, off)];
      end
      pop_s          = '0;
      pop_s[grant_s] = grant_valid_s;
   end

   // Idle only when nothing is queued and nothing is being presented downstream
   always_comb begin
      idle_s = (nonempty_s == '0) && !wb_request_r;
   end

   // FIFO bookkeeping, round-robin pointer and registered write-back output
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_SOURCES; i++) begin
            rd_ptr_r[i] <= '0;
            wr_ptr_r[i] <= '0;
            count_r[i]  <= '0;
         end
         rr_ptr_r     <= '0;
         wb_request_r <= 1'b0;
         wb_packet_r  <= '0;
      end else begin
         for (int i = 0; i < NUM_SOURCES; i++) begin
            count_r[i]  <= count_r[i] + CNT_W'(push_s[i]) - CNT_W'(pop_s[i]);
            wr_ptr_r[i] <= wr_ptr_r[i] + PTR_W'(push_s[i]);
            rd_ptr_r[i] <= rd_ptr_r[i] + PTR_W'(pop_s[i]);
         end
         if (grant_valid_s) begin
            wb_request_r <= 1'b1;
            wb_packet_r  <= mem_r[grant_s][rd_ptr_r[grant_s]];
            rr_ptr_r     <= wrap_index(grant_s, 1);
         end else begin
            wb_request_r <= 1'b0;
         end
      end
   end

   // Payload storage carries no reset; occupancy is tracked solely by the counts
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
         if (push_s[i]) begin
            mem_r[i][wr_ptr_r[i]] <= bus.fu_packet[i];
         end
      end
   end

   assign bus.fu_ready           = ready_s;
   assign bus.idle               = idle_s;
   assign bus.write_back_request = wb_request_r;
   assign bus.write_back_packet  = wb_packet_r;
endmodule

// File: tb/tb_vector_write_back_arbiter.sv
// Randomized and directed bench for vector_write_back_arbiter against a queue-based model
// of the per-source FIFOs and the round-robin write-back rule.
module tb_vector_write_back_arbiter;
   import vector_write_back_arbiter_pkg::*;

   localparam int NUM_SOURCES = 3;
   localparam int FIFO_DEPTH  = 4;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   vector_write_back_arbiter_if #(.NUM_SOURCES(NUM_SOURCES)) bus ();

   vector_write_back_arbiter #(
      .NUM_SOURCES(NUM_SOURCES),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   int           n_vectors     = 0;
   int           n_miscompares = 0;

   data_packet_t model_q [NUM_SOURCES][$];
   int           model_rr  = 0;
   logic         model_req = 1'b0;
   data_packet_t model_pkt = '0;

   logic [NUM_SOURCES-1:0] accepted;
   logic [NUM_SOURCES-1:0] holding;
   logic [TAG_LENGTH-1:0]  next_tag [NUM_SOURCES];
   bit                     sent_40;

   task automatic check_value(input string tag, input logic [127:0] actual, input logic [127:0] expected);
      n_vectors++;
      if (actual !== expected) begin
         n_miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   function automatic logic [NUM_SOURCES-1:0] model_ready();
      logic [NUM_SOURCES-1:0] r;
      for (int i = 0; i < NUM_SOURCES; i++) r[i] = (model_q[i].size() != FIFO_DEPTH);
      return r;
   endfunction

   function automatic logic model_idle();
      int total;
      total = 0;
      for (int i = 0; i < NUM_SOURCES; i++) total += model_q[i].size();
      return (total == 0) && !model_req;
   endfunction

   // Apply the effect of the coming rising edge to the model, using pre-edge state and inputs
   task automatic model_edge();
      logic [NUM_SOURCES-1:0] ready_v;
      int g;
      ready_v = model_ready();
      if (!reset_n) begin
         for (int i = 0; i < NUM_SOURCES; i++) model_q[i].delete();
         model_rr  = 0;
         model_req = 1'b0;
         model_pkt = '0;
      end else begin
         g = -1;
         for (int k = 0; k < NUM_SOURCES; k++) begin
            int idx;
            idx = (model_rr + k) % NUM_SOURCES;
            if (g < 0 && model_q[idx].size() > 0) g = idx;
         end
         if (g >= 0) begin
            model_pkt = model_q[g].pop_front();
            model_req = 1'b1;
            model_rr  = (g + 1) % NUM_SOURCES;
         end else begin
            model_req = 1'b0;
         end
         for (int i = 0; i < NUM_SOURCES; i++)
            if (bus.fu_valid[i] && ready_v[i]) model_q[i].push_back(bus.fu_packet[i]);
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clock);
      #1;
      check_value("wb_request", bus.write_back_request, model_req);
      check_value("wb_packet", bus.write_back_packet, model_pkt);
      check_value("fu_ready", bus.fu_ready, model_ready());
      check_value("idle", bus.idle, model_idle());
   endtask

   task automatic set_src(input int i, input logic v, input logic [TAG_LENGTH-1:0] tag, input logic [63:0] data);
      bus.fu_valid[i]      = v;
      bus.fu_packet[i].tag  = tag;
      bus.fu_packet[i].data = data;
   endtask

   task automatic clear_srcs();
      for (int i = 0; i < NUM_SOURCES; i++) set_src(i, 1'b0, '0, '0);
   endtask

   task automatic pulse_reset();
      clear_srcs();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
   endtask

   initial begin
      clear_srcs();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;

      // Queue packets in every source, then reset: everything is discarded
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NUM_SOURCES; i++) set_src(i, 1'b1, TAG_LENGTH'(8 * i + k), 64'(k + 100 * i));
         step();
      end
      clear_srcs();
      reset_n = 1'b0;
      step();
      check_value("rst_request", bus.write_back_request, 1'b0);
      check_value("rst_packet", bus.write_back_packet, 70'd0);
      check_value("rst_ready", bus.fu_ready, 3'b111);
      check_value("rst_idle", bus.idle, 1'b1);
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check_value("post_rst_quiet", bus.write_back_request, 1'b0);
      end

      // Single packet latency: request high in cycle 2 only
      set_src(1, 1'b1, 6'd5, 64'hDEAD_BEEF_0000_0001);
      step();
      check_value("lat_c1_request", bus.write_back_request, 1'b0);
      clear_srcs();
      step();
      check_value("lat_c2_request", bus.write_back_request, 1'b1);
      check_value("lat_c2_packet", bus.write_back_packet, {6'd5, 64'hDEAD_BEEF_0000_0001});
      step();
      check_value("lat_c3_request", bus.write_back_request, 1'b0);
      check_value("lat_c3_idle", bus.idle, 1'b1);

      // Three simultaneous sources from rr pointer 0
      pulse_reset();
      for (int i = 0; i < NUM_SOURCES; i++) set_src(i, 1'b1, TAG_LENGTH'(i + 1), 64'(i + 1));
      step();
      clear_srcs();
      for (int k = 0; k < NUM_SOURCES; k++) begin
         step();
         check_value("rr_request", bus.write_back_request, 1'b1);
         check_value("rr_tag", bus.write_back_packet.tag, TAG_LENGTH'(k + 1));
      end
      step();

      // Source 0 streams, source 2 injects tag 40 once
      pulse_reset();
      next_tag[0] = 6'd10;
      sent_40     = 1'b0;
      for (int k = 0; k < 14; k++) begin
         set_src(0, 1'b1, next_tag[0], 64'(next_tag[0]));
         set_src(2, (k >= 3) && !sent_40, 6'd40, 64'h4040_4040_4040_4040);
         accepted = bus.fu_valid & bus.fu_ready;
         step();
         if (accepted[0]) next_tag[0] = next_tag[0] + 6'd1;
         if (accepted[2]) sent_40 = 1'b1;
      end
      clear_srcs();
      for (int k = 0; k < 12; k++) step();

      // All sources stream every cycle; output must never bubble once started
      pulse_reset();
      for (int i = 0; i < NUM_SOURCES; i++) next_tag[i] = TAG_LENGTH'(16 * i);
      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < NUM_SOURCES; i++) set_src(i, 1'b1, next_tag[i], {32'(i), 32'(next_tag[i])});
         accepted = bus.fu_valid & bus.fu_ready;
         step();
         if (k >= 1) check_value("stream_request", bus.write_back_request, 1'b1);
         for (int i = 0; i < NUM_SOURCES; i++) if (accepted[i]) next_tag[i] = next_tag[i] + 6'd1;
      end
      clear_srcs();
      for (int k = 0; k < 16; k++) step();

      // Random traffic with occasional reset; a refused packet is held until taken
      holding = '0;
      for (int k = 0; k < 10000; k++) begin
         reset_n = ($urandom_range(0, 299) != 0);
         for (int i = 0; i < NUM_SOURCES; i++) begin
            if (!holding[i]) begin
               set_src(i, ($urandom_range(0, 3) != 0), TAG_LENGTH'($urandom()), {$urandom(), $urandom()});
            end
         end
         accepted = bus.fu_valid & bus.fu_ready;
         step();
         holding = (reset_n == 1'b1) ? (bus.fu_valid & ~accepted) : '0;
      end
      reset_n = 1'b1;
      clear_srcs();
      for (int k = 0; k < 16; k++) step();
      check_value("final_idle", bus.idle, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end
endmodule
